// File: rtl/row_packer.sv
// Row packer: collects a row-major stream of result elements into N-lane words and
// writes one packed word per row to the output row memory, then pulses done.
module row_packer #(
  parameter  int unsigned ELEM_W = 8,
  parameter  int unsigned IDX_W  = 3,
  localparam int unsigned N      = 2 ** IDX_W,
  localparam int unsigned RowW   = N * ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_i,
  input  logic [IDX_W-1:0]  in_j,
  output logic              in_ready,
  input  logic              mem_busy,
  output logic              mem_wen,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [RowW-1:0]   mem_wdata,
  output logic              done,
  output logic              busy,
  output logic              order_err
);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   row_q, row_d;
  logic [IDX_W-1:0]   col_q, col_d;
  logic [RowW-1:0]    buf_q, buf_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic [RowW-1:0]    wdata_q, wdata_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               mem_wen_q, mem_wen_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               accept;

  assign accept = in_valid & in_ready_q;

  // Next-state logic: counters, lane placement, index check and write handshake.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          err_d   = 1'b0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (accept) begin
          // Placement follows the internal column counter; in_i/in_j are only checked.
          for (int unsigned k = 0; k < N; k++) begin
            if (col_q == IDX_W'(k)) begin
              buf_d[k*ELEM_W +: ELEM_W] = in_data;
            end
          end
          if ((in_i != row_q) || (in_j != col_q)) begin
            err_d = 1'b1;
          end
          col_d = col_q + 1'b1;
          if (col_q == IDX_W'(N - 1)) begin
            // Capture the completed row so mem_wdata stays stable while busy and after.
            state_d = StWrite;
            addr_d  = row_q;
            wdata_d = buf_d;
          end
        end
      end
      StWrite: begin
        if (!mem_busy) begin
          row_d   = row_q + 1'b1;
          state_d = (row_q == IDX_W'(N - 1)) ? StDone : StCollect;
        end
      end
      StDone: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          err_d   = 1'b0;
          state_d = StCollect;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered status outputs decoded from the next state.
  always_comb begin
    in_ready_d = (state_d == StCollect);
    mem_wen_d  = (state_d == StWrite);
    done_d     = (state_d == StDone);
    busy_d     = (state_d != StIdle);
  end

  // State and output registers; reset discards any partial row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      buf_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      mem_wen_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      buf_q      <= buf_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      mem_wen_q  <= mem_wen_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign order_err = err_q;

endmodule

// File: tb/tb_row_packer.sv
// Directed bench for row_packer: reset, nominal frame, backpressure, order error,
// mid-frame reset and back-to-back frames.
module tb_row_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [2:0]  in_i;
  logic [2:0]  in_j;
  logic        in_ready;
  logic        mem_busy;
  logic        mem_wen;
  logic [2:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        done;
  logic        busy;
  logic        order_err;

  int errors = 0;
  int checks = 0;

  // Write/done monitor
  int          cyc = 0;
  int          nw = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [2:0]  wr_addr [64];
  logic [63:0] wr_data [64];
  int          wr_cyc  [64];

  row_packer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_i     (in_i),
    .in_j     (in_j),
    .in_ready (in_ready),
    .mem_busy (mem_busy),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .done     (done),
    .busy     (busy),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wen === 1'b1 && mem_busy === 1'b0 && nw < 64) begin
      wr_addr[nw] <= mem_addr;
      wr_data[nw] <= mem_wdata;
      wr_cyc[nw]  <= cyc;
      nw          <= nw + 1;
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] row_word(input int r, input logic [7:0] x);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(8 * r + j) ^ x;
    return w;
  endfunction

  // Offer one element and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d, input int ti, input int tj);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (in_ready !== 1'b1) chk("send_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_i     = 3'(ti);
    in_j     = 3'(tj);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_rows(input int r0, input int r1, input logic [7:0] x);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < 8; c++) send(8'(8 * r + c) ^ x, r, c);
  endtask

  // Returns at the sample point of the DONE cycle.
  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int base;
  int nw_hold;

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    in_i = 3'd0; in_j = 3'd0; mem_busy = 1'b0;

    // Reset / idle
    step(); step();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_mem_wen", {63'd0, mem_wen}, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    rst = 1'b1;
    step(); step(); step();
    chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
    chk("idle_mem_wen", {63'd0, mem_wen}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_done", {63'd0, done}, 64'd0);
    chk("idle_order_err", {63'd0, order_err}, 64'd0);
    chk("idle_mem_addr", {61'd0, mem_addr}, 64'd0);
    chk("idle_mem_wdata", mem_wdata, 64'd0);
    in_valid = 1'b0;

    // Nominal frame
    base = nw;
    pulse_start();
    chk("start_in_ready", {63'd0, in_ready}, 64'd1);
    chk("start_busy", {63'd0, busy}, 64'd1);
    send_rows(0, 7, 8'h00);
    wait_done();
    step();
    chk("nom_writes", 64'(nw - base), 64'd8);
    chk("nom_row0_addr", {61'd0, wr_addr[base]}, 64'd0);
    chk("nom_row0_data", wr_data[base], 64'h0706050403020100);
    chk("nom_row7_addr", {61'd0, wr_addr[base+7]}, 64'd7);
    chk("nom_row7_data", wr_data[base+7], 64'h3F3E3D3C3B3A3938);
    for (int r = 1; r < 7; r++) begin
      chk("nom_row_addr", {61'd0, wr_addr[base+r]}, 64'(r));
      chk("nom_row_data", wr_data[base+r], row_word(r, 8'h00));
    end
    chk("nom_done_cnt", 64'(done_cnt), 64'd1);
    chk("nom_done_delay", 64'(done_cyc - wr_cyc[base+7]), 64'd1);
    chk("nom_done_low", {63'd0, done}, 64'd0);
    chk("nom_busy_low", {63'd0, busy}, 64'd0);
    chk("nom_order_err", {63'd0, order_err}, 64'd0);
    chk("nom_wdata_hold", mem_wdata, 64'h3F3E3D3C3B3A3938);

    // Backpressure on row 2
    base = nw;
    pulse_start();
    send_rows(0, 2, 8'h00);
    mem_busy = 1'b1;
    chk("bp_wen0", {63'd0, mem_wen}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_wen", {63'd0, mem_wen}, 64'd1);
      chk("bp_addr", {61'd0, mem_addr}, 64'd2);
      chk("bp_data", mem_wdata, row_word(2, 8'h00));
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    chk("bp_no_write", 64'(nw - base), 64'd2);
    mem_busy = 1'b0;
    step();
    chk("bp_one_write", 64'(nw - base), 64'd3);
    chk("bp_resume", {63'd0, in_ready}, 64'd1);
    chk("bp_wen_off", {63'd0, mem_wen}, 64'd0);
    chk("bp_wr_data", wr_data[base+2], row_word(2, 8'h00));
    send_rows(3, 7, 8'h00);
    wait_done();
    step();
    chk("bp_writes", 64'(nw - base), 64'd8);

    // Order error: element (0,3) tagged as j=4
    base = nw;
    pulse_start();
    for (int c = 0; c < 3; c++) send(8'(c), 0, c);
    chk("oe_before", {63'd0, order_err}, 64'd0);
    send(8'h03, 0, 4);
    chk("oe_set", {63'd0, order_err}, 64'd1);
    for (int c = 4; c < 8; c++) send(8'(c), 0, c);
    send_rows(1, 7, 8'h00);
    wait_done();
    chk("oe_at_done", {63'd0, order_err}, 64'd1);
    step();
    chk("oe_after_done", {63'd0, order_err}, 64'd1);
    chk("oe_lane3", wr_data[base], 64'h0706050403020100);
    pulse_start();
    chk("oe_cleared", {63'd0, order_err}, 64'd0);

    // Reset mid-frame after 13 accepts
    for (int k = 0; k < 13; k++) send(8'h80 | 8'(k), k / 8, k % 8);
    nw_hold = nw;
    rst = 1'b0;
    #1;
    chk("mr_wen", {63'd0, mem_wen}, 64'd0);
    chk("mr_busy", {63'd0, busy}, 64'd0);
    chk("mr_wdata", mem_wdata, 64'd0);
    step(); step();
    rst = 1'b1;
    step(); step(); step();
    chk("mr_no_write", 64'(nw), 64'(nw_hold));
    chk("mr_wen_after", {63'd0, mem_wen}, 64'd0);
    base = nw;
    pulse_start();
    send_rows(0, 7, 8'hFF);
    chk("mr_first_addr", {61'd0, wr_addr[base]}, 64'd0);
    chk("mr_first_data", wr_data[base], row_word(0, 8'hFF));
    wait_done();

    // Back-to-back: start during DONE
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    chk("b2b_done_low", {63'd0, done}, 64'd0);
    base = nw;
    send_rows(0, 0, 8'h3C);
    step();
    chk("b2b_write", 64'(nw - base), 64'd1);
    chk("b2b_addr", {61'd0, wr_addr[base]}, 64'd0);
    chk("b2b_data", wr_data[base], row_word(0, 8'h3C));
    chk("b2b_order_err", {63'd0, order_err}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
